// File: rtl/mult_div_seq_pkg.sv
// Shared definitions for the multi-cycle mult/div sequencer: the ALU control codes it
// accepts, its state encoding and the default data width.
package mult_div_seq_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [4:0] ALU_MULT  = 5'b01111;
    localparam logic [4:0] ALU_MULTU = 5'b10000;
    localparam logic [4:0] ALU_DIV   = 5'b10001;
    localparam logic [4:0] ALU_DIVU  = 5'b10010;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } mdState_e;

    function automatic logic isMdOp(input logic [4:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_seq_if.sv
// Request/result bundle between decode and the mult/div sequencer.
interface mult_div_seq_if
    import mult_div_seq_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
);

    logic             start;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mfhi;
    logic             mflo;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, op, a, b, mfhi, mflo, mthi, mtlo,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, a, b, mfhi, mflo, mthi, mtlo,
        output hi, lo, busy, done, stall
    );

endinterface

// File: rtl/mult_div_datapath.sv
// Radix-2 iteration engine on unsigned magnitudes: shift-add multiply or restoring divide,
// one bit per step, with the iteration counter that tells the sequencer when to stop.
module mult_div_datapath
    import mult_div_seq_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             isDiv,
    input  logic [WIDTH-1:0] magA,
    input  logic [WIDTH-1:0] magB,
    output logic [WIDTH-1:0] accHi,
    output logic [WIDTH-1:0] accLo,
    output logic             lastIter
);

    localparam int CW = $clog2(ITERS) + 1;

    logic [WIDTH-1:0] operand;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH-1:0] divDiff;
    logic             divFits;

    // Multiply keeps the multiplier in accLo and retires one product bit per step into it;
    // divide shifts the dividend out of accLo into the remainder and shifts quotient bits in.
    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        divShift = {accHi, accLo[WIDTH-1]};
        divFits  = divShift >= {1'b0, operand};
        divDiff  = divShift[WIDTH-1:0] - operand;
        lastIter = (count == CW'(ITERS - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accHi   <= '0;
            accLo   <= '0;
            operand <= '0;
            count   <= '0;
        end else if (load) begin
            accHi   <= '0;
            accLo   <= magA;
            operand <= magB;
            count   <= '0;
        end else if (step) begin
            count <= count + CW'(1);
            if (isDiv) begin
                accHi <= divFits ? divDiff : divShift[WIDTH-1:0];
                accLo <= {accLo[WIDTH-2:0], divFits};
            end else begin
                accHi <= mulSum[WIDTH:1];
                accLo <= {mulSum[0], accLo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/mult_div_seq.sv
// Multi-cycle mult/multu/div/divu sequencer: owns HI/LO, applies sign correction after the
// unsigned iterations, and raises stall for HI/LO moves while an operation is in flight.
module mult_div_seq
    import mult_div_seq_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int ITERS = WIDTH
) (
    input logic           clk,
    input logic           reset,
    mult_div_seq_if.slave bus
);

    mdState_e           state;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic [WIDTH-1:0]   aLatch;
    logic               signA;
    logic               signB;
    logic               divOp;
    logic               divByZero;

    logic               opValid;
    logic               opSigned;
    logic               opDiv;
    logic               load;
    logic               step;
    logic               lastIter;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [WIDTH-1:0]   accHi;
    logic [WIDTH-1:0]   accLo;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // The remainder takes the dividend's sign; quotient and product take the XOR of both.
    always_comb begin
        opValid  = isMdOp(bus.op);
        opSigned = (bus.op == ALU_MULT) || (bus.op == ALU_DIV);
        opDiv    = (bus.op == ALU_DIV) || (bus.op == ALU_DIVU);
        magA     = (opSigned && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        magB     = (opSigned && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        load     = bus.start && opValid;
        step     = (state == MUL) || (state == DIV);
        product  = (signA ^ signB) ? -{accHi, accLo} : {accHi, accLo};
        quot     = (signA ^ signB) ? -accLo : accLo;
        rem      = signA ? -accHi : accHi;
    end

    mult_div_datapath #(
        .WIDTH (WIDTH),
        .ITERS (ITERS)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .isDiv    (state == DIV),
        .magA     (magA),
        .magB     (magB),
        .accHi    (accHi),
        .accLo    (accLo),
        .lastIter (lastIter)
    );

    // A valid start always wins, so a start while busy abandons the old operation unwritten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            hiReg     <= '0;
            loReg     <= '0;
            aLatch    <= '0;
            signA     <= 1'b0;
            signB     <= 1'b0;
            divOp     <= 1'b0;
            divByZero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (bus.mthi) hiReg <= bus.a;
                if (bus.mtlo) loReg <= bus.a;
            end
            if (load) begin
                state     <= opDiv ? DIV : MUL;
                busy      <= 1'b1;
                aLatch    <= bus.a;
                signA     <= opSigned && bus.a[WIDTH-1];
                signB     <= opSigned && bus.b[WIDTH-1];
                divOp     <= opDiv;
                divByZero <= opDiv && (bus.b == '0);
            end else begin
                case (state)
                    MUL, DIV: begin
                        if (lastIter) state <= FIX;
                    end
                    FIX: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (divByZero) begin
                            hiReg <= aLatch;
                            loReg <= '1;
                        end else if (divOp) begin
                            hiReg <= rem;
                            loReg <= quot;
                        end else begin
                            {hiReg, loReg} <= product;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.hi    = hiReg;
    assign bus.lo    = loReg;
    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.stall = busy && (bus.mfhi || bus.mflo || bus.mthi || bus.mtlo);

endmodule

// File: tb/tb_mult_div_seq.sv
// Bench for mult_div_seq: directed literal cases plus randomized traffic, checked every
// cycle against an arithmetic model of HI/LO, busy, done and stall.
module tb_mult_div_seq;
    import mult_div_seq_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mult_div_seq_if #(.WIDTH(32)) bus();

    mult_div_seq #(
        .WIDTH (32),
        .ITERS (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic        mBusy   = 1'b0;
    logic        mDone   = 1'b0;
    logic [31:0] mHi     = '0;
    logic [31:0] mLo     = '0;
    logic [63:0] mResult = '0;
    int          mRemain = 0;
    logic        mWasBusy;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic validOp(input logic [4:0] o);
        return o inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
    endfunction

    // Returns {hi, lo} straight from the arithmetic definition of each operation.
    function automatic logic [63:0] expectedResult(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] ux;
        logic [63:0] uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        case (o)
            ALU_MULT:  return 64'(sx * sy);
            ALU_MULTU: return ux * uy;
            ALU_DIV: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            ALU_DIVU: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Reference model: an accepted start schedules its result 33 edges later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mBusy   = 1'b0;
            mDone   = 1'b0;
            mHi     = '0;
            mLo     = '0;
            mRemain = 0;
        end else begin
            mWasBusy = mBusy;
            mDone    = 1'b0;
            if (!mWasBusy) begin
                if (bus.mthi) mHi = bus.a;
                if (bus.mtlo) mLo = bus.a;
            end
            if (bus.start && validOp(bus.op)) begin
                mResult = expectedResult(bus.op, bus.a, bus.b);
                mRemain = 33;
                mBusy   = 1'b1;
            end else if (mWasBusy) begin
                mRemain = mRemain - 1;
                if (mRemain == 0) begin
                    {mHi, mLo} = mResult;
                    mBusy      = 1'b0;
                    mDone      = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("hi", 64'(bus.hi), 64'(mHi));
        checkOutput("lo", 64'(bus.lo), 64'(mLo));
        checkOutput("busy", 64'(bus.busy), 64'(mBusy));
        checkOutput("done", 64'(bus.done), 64'(mDone));
        checkOutput("stall", 64'(bus.stall),
                    64'(mBusy && (bus.mfhi || bus.mflo || bus.mthi || bus.mtlo)));
    end

    // mv = {mfhi, mflo, mthi, mtlo}; each call covers exactly one rising edge.
    task automatic applyStimulus(input logic st, input logic [4:0] o, input logic [31:0] x,
                                 input logic [31:0] y, input logic [3:0] mv);
        bus.start = st;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        {bus.mfhi, bus.mflo, bus.mthi, bus.mtlo} = mv;
        @(posedge clk);
        #1;
    endtask

    task automatic waitDone(input string name, input logic [3:0] mv, input int expLatency);
        int n = 0;
        while (!bus.done && n < 40) begin
            applyStimulus(1'b0, 5'd0, $urandom, $urandom, mv);
            n++;
        end
        checkOutput({name, " latency"}, 64'(n), 64'(expLatency));
    endtask

    task automatic runOp(input string name, input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] expected);
        applyStimulus(1'b1, o, x, y, 4'b0000);
        waitDone(name, 4'b0000, 33);
        checkOutput({name, " result"}, {bus.hi, bus.lo}, expected);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'(0 - $urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [4:0] pickOp();
        case ($urandom_range(0, 9))
            0, 1:    return ALU_MULT;
            2, 3:    return ALU_MULTU;
            4, 5:    return ALU_DIV;
            6, 7:    return ALU_DIVU;
            default: return 5'($urandom_range(0, 14));
        endcase
    endfunction

    initial begin
        logic [3:0] mv;
        int         gap;

        bus.start = 1'b0;
        bus.op    = 5'd0;
        bus.a     = '0;
        bus.b     = '0;
        {bus.mfhi, bus.mflo, bus.mthi, bus.mtlo} = 4'b0000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        checkOutput("reset hi", 64'(bus.hi), 64'h0);
        checkOutput("reset lo", 64'(bus.lo), 64'h0);
        checkOutput("reset busy", 64'(bus.busy), 64'h0);
        checkOutput("reset done", 64'(bus.done), 64'h0);

        runOp("multu max", ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 4'b0000);
        checkOutput("done one cycle", 64'(bus.done), 64'h0);
        runOp("mult -7*3", ALU_MULT, 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB);
        runOp("div -7/2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        runOp("div 7/-2", ALU_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
        runOp("divu by zero", ALU_DIVU, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF);
        runOp("div min/-1", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        runOp("mult min*min", ALU_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

        applyStimulus(1'b1, ALU_DIVU, 32'd1000, 32'd7, 4'b0000);
        repeat (4) applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 4'b0000);
        bus.mflo = 1'b1;
        #1 checkOutput("mflo stall", 64'(bus.stall), 64'h1);
        waitDone("mflo divu", 4'b0100, 29);
        checkOutput("stall on done", 64'(bus.stall), 64'h0);
        checkOutput("lo on done", 64'(bus.lo), 64'd142);
        checkOutput("hi on done", 64'(bus.hi), 64'd6);

        applyStimulus(1'b1, ALU_MULT, 32'd3, 32'd4, 4'b0000);
        applyStimulus(1'b0, 5'd0, 32'h1234, 32'h0, 4'b0001);
        checkOutput("mtlo busy ignored", 64'(bus.lo), 64'd142);
        waitDone("mult 3*4", 4'b0000, 32);
        checkOutput("mult 3*4 result", {bus.hi, bus.lo}, 64'd12);
        applyStimulus(1'b0, 5'd0, 32'd5, 32'h0, 4'b0010);
        checkOutput("mthi idle", 64'(bus.hi), 64'd5);

        applyStimulus(1'b1, ALU_MULTU, 32'd9, 32'd10, 4'b0010);
        checkOutput("mthi with start", 64'(bus.hi), 64'd9);
        waitDone("multu 9*10", 4'b0000, 33);
        checkOutput("multu 9*10 result", {bus.hi, bus.lo}, 64'd90);

        applyStimulus(1'b1, 5'b00011, 32'd1, 32'd1, 4'b0000);
        checkOutput("bad op ignored", 64'(bus.busy), 64'h0);

        applyStimulus(1'b1, ALU_MULTU, 32'd2, 32'd3, 4'b0000);
        repeat (4) applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 4'b0000);
        applyStimulus(1'b1, ALU_DIVU, 32'd9, 32'd2, 4'b0000);
        waitDone("abort", 4'b0000, 33);
        checkOutput("abort result", {bus.hi, bus.lo}, 64'h0000_0001_0000_0004);

        applyStimulus(1'b1, ALU_MULTU, 32'd1000, 32'd1000, 4'b0000);
        repeat (9) applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 4'b0000);
        bus.mflo = 1'b1;
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset busy", 64'(bus.busy), 64'h0);
        checkOutput("async reset done", 64'(bus.done), 64'h0);
        checkOutput("async reset hilo", {bus.hi, bus.lo}, 64'h0);
        checkOutput("async reset stall", 64'(bus.stall), 64'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        bus.mflo = 1'b0;

        for (int i = 0; i < 200; i++) begin
            mv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            applyStimulus(1'b1, pickOp(), pickOperand(), pickOperand(), mv);
            gap = $urandom_range(0, 40);
            for (int k = 0; k < gap; k++) begin
                mv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
                if ($urandom_range(0, 15) == 0)
                    applyStimulus(1'b1, 5'($urandom_range(0, 14)), $urandom, $urandom, mv);
                else
                    applyStimulus(1'b0, 5'd0, $urandom, $urandom, mv);
            end
        end

        repeat (40) applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 4'b0000);
        checkOutput("final idle", 64'(bus.busy), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
